// File: rtl/mult_seq.sv
// Iterative shift-add multiplier producing a full 2*WIDTH product into hi/lo.
// Operands are reduced to magnitudes up front; the sign is reapplied once at the end.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic               neg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] result;

    // The most negative operand maps onto itself, which is exactly its unsigned magnitude.
    always_comb begin
        a_mag    = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag    = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
        acc_next = mplier[0] ? (acc + mcand) : acc;
        result   = neg ? (~acc + 1'b1) : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    {hi, lo} <= result;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Directed self-checking bench for mult_seq: hand-computed products, latency,
// ignored starts, back-to-back operation and asynchronous reset abort.
module tb_mult_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    mult_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; request is held across exactly one rising edge (E0).
    task automatic applyStimulus(input logic sgn, input logic [31:0] op_a, input logic [31:0] op_b);
        start     = 1'b1;
        is_signed = sgn;
        a         = op_a;
        b         = op_b;
        @(negedge clk);
        start     = 1'b0;
        is_signed = 1'b0;
        a         = 32'hDEAD_BEEF;
        b         = 32'hCAFE_F00D;
    endtask

    // Counts rising edges since E0 until done shows up; busy must stay high meanwhile.
    task automatic waitDone(input string tag, input int already);
        int edges;
        int busy_low;
        edges    = already;
        busy_low = 0;
        while (!done && edges < 100) begin
            if (busy !== 1'b1) busy_low++;
            @(negedge clk);
            edges++;
        end
        checkOutput({tag, " latency"}, 64'(edges), 64'd33);
        checkOutput({tag, " busy gaps"}, 64'(busy_low), 64'd0);
        checkOutput({tag, " busy at done"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic runOp(input string tag, input logic sgn, input logic [31:0] op_a,
                         input logic [31:0] op_b, input logic [63:0] exp);
        applyStimulus(sgn, op_a, op_b);
        waitDone(tag, 0);
        checkOutput({tag, " product"}, {hi, lo}, exp);
        @(negedge clk);
        checkOutput({tag, " done width"}, {63'd0, done}, 64'd0);
        checkOutput({tag, " hold"}, {hi, lo}, exp);
    endtask

    initial begin
        int pulses;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset state", {busy, done, hi, lo}, 66'd0);
        rst = 1'b0;
        @(negedge clk);

        runOp("umax",      1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        runOp("s -3*7",    1'b1, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB);
        runOp("u fd*7",    1'b0, 32'hFFFF_FFFD, 32'd7,         64'h0000_0006_FFFF_FFEB);
        runOp("s min*min", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        runOp("s min*1",   1'b1, 32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000);
        runOp("s max*max", 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        runOp("s -1*-1",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        runOp("s 5*-4",    1'b1, 32'd5,         32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFEC);

        // Zero product with a start pulse that must be ignored while busy
        applyStimulus(1'b0, 32'h1234_5678, 32'd0);
        repeat (9) @(negedge clk);
        checkOutput("ignored busy", {63'd0, busy}, 64'd1);
        start = 1'b1; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        waitDone("zero", 10);
        checkOutput("zero product", {hi, lo}, 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checkOutput("no second done", 64'(pulses), 64'd0);
        checkOutput("zero hold", {hi, lo}, 64'd0);

        // Back-to-back: second start issued in the done cycle
        applyStimulus(1'b0, 32'd6, 32'd7);
        waitDone("b2b first", 0);
        checkOutput("b2b first product", {hi, lo}, 64'd42);
        applyStimulus(1'b0, 32'h0001_0000, 32'h0001_0000);
        checkOutput("b2b accepted", {63'd0, busy}, 64'd1);
        checkOutput("b2b hold during op", {hi, lo}, 64'd42);
        waitDone("b2b second", 0);
        checkOutput("b2b second product", {hi, lo}, 64'h0000_0001_0000_0000);

        // Reset mid-operation, asserted between edges
        @(negedge clk);
        applyStimulus(1'b0, 32'd3, 32'd4);
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset", {busy, done, hi, lo}, 66'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        checkOutput("no done after reset", 64'(pulses), 64'd0);
        runOp("post reset 3*4", 1'b0, 32'd3, 32'd4, 64'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Multi-cycle shift-add integer multiplier for the ALU/HI-LO path.
- Computes the full double-width product of two operands, signed or unsigned, and writes it to hi/lo.
- It is the counterpart of the combinational unsigned divider: it reconstructs the product that division decomposes.
- It is iterative so that its combinational depth stays off the critical path.
- The pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising clk when not busy
- is_signed  input  1  1 = two's-complement multiply (MULT), 0 = unsigned (MULTU); sampled with start
- a  input  WIDTH  multiplicand; sampled with start
- b  input  WIDTH  multiplier; sampled with start
- busy  output  1  operation in progress; new start ignored
- done  output  1  single-cycle pulse; hi/lo valid and updated
- hi  output  WIDTH  upper half of product
- lo  output  WIDTH  lower half of product

Behaviour:
- Reset:
  - Asynchronous and immediate.
  - state=IDLE, busy=0, done=0, hi=0, lo=0, internal accumulator/counter=0.
  - Reset asserted mid-operation aborts it; no done pulse follows.
- States: IDLE, CALC, FIN.
- IDLE:
  - On an edge (E0) with start=1, latch |a| and |b| into internal registers.
  - |x| is the two's-complement magnitude when is_signed=1 and x[WIDTH-1]=1; otherwise x unchanged.
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits unsigned WIDTH bits.
  - Latch neg = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Clear the 2*WIDTH accumulator, clear the counter, go to CALC, busy=1.
- CALC, one iteration per edge (E1..E_WIDTH):
  - If multiplier LSB=1, add multiplicand (shifted to the current bit weight) into the accumulator.
  - Then shift the multiplier right by 1.
  - Counter increments each iteration.
  - After the WIDTH-th iteration, go to FIN.
- FIN, one edge (E_WIDTH+1):
  - {hi,lo} <= neg ? -(accumulator) mod 2^(2*WIDTH) : accumulator.
  - done=1 for exactly this one cycle, busy=0, state=IDLE.
- Latency:
  - start sampled at E0; done high in the cycle following edge E(WIDTH+1).
  - That is 33 edges for WIDTH=32, fixed and independent of operand values. No early termination.
- busy is 1 from after E0 until E(WIDTH+1); done and busy are never both 1.
- start while busy=1: ignored, with no effect on the in-flight operation or on latched operands.
- start during the done cycle: accepted; back-to-back operation begins on that edge.
- hi/lo:
  - Change only at FIN or reset.
  - Hold the last result indefinitely otherwise, including throughout a subsequent operation.
- Width rules:
  - All arithmetic is modulo 2^(2*WIDTH).
  - Unsigned result is the exact product.
  - Signed result is the exact two's-complement product. No overflow is possible in 2*WIDTH bits.
- is_signed, a and b are don't-care except at the accepting edge.

Test Plan:
- Unsigned max: is_signed=0, a=b=0xFFFFFFFF, start 1 cycle -> done exactly 33 edges later, hi=0xFFFFFFFE, lo=0x00000001, busy high for the intervening cycles.
- Signed mixed: is_signed=1, a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Same operands with is_signed=0 -> hi=0x00000006, lo=0xFFFFFFEB.
- Signed corner: is_signed=1, a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Also a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Zero and ignored start:
  - Run a=0x12345678, b=0.
  - Pulse start with a=5, b=5 at cycle 10 while busy.
  - Required: done once, hi=lo=0; no second done; hi/lo not 25.
- Back-to-back:
  - Run 6*7.
  - Assert start again during its done cycle with 0x10000*0x10000.
  - Required: first done gives lo=42, hi=0; second done exactly 33 edges after the second start gives hi=0x00000001, lo=0.
- Reset mid-op:
  - Start 3*4; assert rst asynchronously (between edges) at cycle 15.
  - Required: busy, done, hi and lo go to 0 immediately, with no done pulse afterwards.
  - After release, a new 3*4 gives lo=12 after 33 edges.
